// File: rtl/eq_pair_gen.sv
// Operand-pair source for the equality-compare datapath: exhaustive sweep or
// seeded LFSR-random (a, b, a==b) pairs delivered over a valid/ready handshake.
module eq_pair_gen #(
  parameter int          WIDTH      = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          RAND_COUNT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               exp_eq,
  output logic               valid,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   pair_cnt
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic            mode_r;
  logic [15:0]     lfsr;
  logic [PW-1:0]   idx;

  logic [15:0]     lfsr_adv;
  logic [PW-1:0]   idx_adv;
  logic [WIDTH-1:0] adv_a, adv_b, first_a, first_b;
  logic            last_xfer;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Bit 15 of the LFSR forces b = a, biasing the stream to about half equal pairs.
  function automatic logic [WIDTH-1:0] rand_a(input logic [15:0] l);
    return l[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rand_b(input logic [15:0] l);
    return l[15] ? l[WIDTH-1:0] : l[PW-1:WIDTH];
  endfunction

  always_comb begin
    lfsr_adv = lfsr_step(lfsr);
    idx_adv  = idx + PW'(1);
    if (mode_r) begin
      adv_a = rand_a(lfsr_adv);
      adv_b = rand_b(lfsr_adv);
    end else begin
      adv_a = idx_adv[PW-1:WIDTH];
      adv_b = idx_adv[WIDTH-1:0];
    end
    first_a = mode ? rand_a(LFSR_SEED) : '0;
    first_b = mode ? rand_b(LFSR_SEED) : '0;
    if (mode_r) last_xfer = (pair_cnt == CW'(RAND_COUNT - 1));
    else        last_xfer = (idx == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      lfsr     <= LFSR_SEED;
      idx      <= '0;
      a        <= '0;
      b        <= '0;
      exp_eq   <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pair_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_r   <= mode;
            pair_cnt <= '0;
            lfsr     <= LFSR_SEED;
            idx      <= '0;
            a        <= first_a;
            b        <= first_b;
            exp_eq   <= (first_a == first_b);
            valid    <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // The next pair is loaded on the same edge as the transfer, so no bubbles.
          if (valid && ready) begin
            pair_cnt <= pair_cnt + CW'(1);
            if (last_xfer) begin
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              lfsr   <= lfsr_adv;
              idx    <= idx_adv;
              a      <= adv_a;
              b      <= adv_b;
              exp_eq <= (adv_a == adv_b);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
